// File: rtl/bout_referee_pkg.sv
// Shared types for the bout referee: FSM state encoding, touch decision
// codes, winner codes and a saturating score increment.
package bout_referee_pkg;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_READY   = 3'd1,
    ST_FENCE   = 3'd2,
    ST_LOCKOUT = 3'd3,
    ST_HALT    = 3'd4,
    ST_OVER    = 3'd5
  } ref_state_t;

  localparam logic [1:0] WHO_NONE   = 2'b00;
  localparam logic [1:0] WHO_PLAYER = 2'b01;
  localparam logic [1:0] WHO_OPP    = 2'b10;
  localparam logic [1:0] WHO_DOUBLE = 2'b11;

  localparam logic [1:0] WINNER_NONE   = 2'b00;
  localparam logic [1:0] WINNER_PLAYER = 2'b01;
  localparam logic [1:0] WINNER_OPP    = 2'b10;

  // Score +1 that sticks at the winning score so the 4-bit counter never wraps
  function automatic logic [3:0] sat_inc(input logic [3:0] value, input logic [3:0] limit);
    return (value >= limit) ? limit : value + 4'd1;
  endfunction

endpackage

// File: rtl/bout_referee_sec_tick_gen.sv
// One-second prescaler. The cycle in which restart is high counts as the
// first cycle of a new second, so tick fires CYCLES_PER_SEC-1 cycles later.
module sec_tick_gen #(
  parameter int CYCLES_PER_SEC = 74_250_000
) (
  input  logic clk_pixel_in,
  input  logic rst_n_in,
  input  logic restart,
  output logic tick
);

  localparam int CNT_W = (CYCLES_PER_SEC > 1) ? $clog2(CYCLES_PER_SEC) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CYCLES_PER_SEC - 1);
  localparam logic [CNT_W-1:0] AFTER_RESTART = (CYCLES_PER_SEC > 1) ? CNT_W'(1) : '0;

  logic [CNT_W-1:0] cnt;

  // Free-running modulo counter, realigned whenever a timed phase begins
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (restart) begin
      cnt <= AFTER_RESTART;
    end else if (cnt == LAST_CNT) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + 1'b1;
    end
  end

  assign tick = (cnt == LAST_CNT) && !restart;

endmodule

// File: rtl/bout_referee.sv
// Match-level sequencer: gates fencing, resolves single/double touches,
// keeps score and runs the countdown, halt and match-over phases.
module bout_referee
  import bout_referee_pkg::*;
#(
  parameter int CYCLES_PER_SEC = 74_250_000,
  parameter int LOCKOUT_CYCLES = 2_970_000,
  parameter int READY_SECS     = 3,
  parameter int HALT_SECS      = 2,
  parameter int WIN_SCORE      = 5
) (
  input  logic       clk_pixel_in,
  input  logic       rst_n_in,
  input  logic       start_in,
  input  logic       player_touch_in,
  input  logic       opponent_touch_in,
  output logic       fight_enable_out,
  output logic       reset_positions_out,
  output logic [3:0] player_score_out,
  output logic [3:0] opponent_score_out,
  output logic [3:0] countdown_out,
  output logic       touch_event_out,
  output logic [1:0] touch_who_out,
  output logic [1:0] winner_out,
  output logic [2:0] state_out
);

  localparam int LOCK_W = (LOCKOUT_CYCLES > 1) ? $clog2(LOCKOUT_CYCLES) : 1;
  localparam logic [LOCK_W-1:0] LOCK_LOAD = LOCK_W'(LOCKOUT_CYCLES - 1);
  localparam logic [3:0] WIN     = 4'(WIN_SCORE);
  localparam logic [3:0] WIN_M1  = 4'(WIN_SCORE - 1);
  localparam logic [3:0] READY_N = 4'(READY_SECS);
  localparam logic [3:0] HALT_N  = 4'(HALT_SECS);

  ref_state_t        state;
  logic [LOCK_W-1:0] lock_cnt;
  logic              first_is_player;
  logic              restart_q;
  logic              sec_tick;
  logic              second_touch;
  logic              do_double;
  logic              do_single;
  logic              annul_double;

  sec_tick_gen #(
    .CYCLES_PER_SEC(CYCLES_PER_SEC)
  ) u_sec_tick_gen (
    .clk_pixel_in(clk_pixel_in),
    .rst_n_in    (rst_n_in),
    .restart     (restart_q),
    .tick        (sec_tick)
  );

  // Decide this cycle whether a point is resolved and whether it is a double
  always_comb begin
    second_touch = first_is_player ? opponent_touch_in : player_touch_in;
    do_double    = ((state == ST_FENCE) && player_touch_in && opponent_touch_in) ||
                   ((state == ST_LOCKOUT) && second_touch);
    do_single    = (state == ST_LOCKOUT) && !second_touch && (lock_cnt == '0);
    annul_double = (player_score_out >= WIN_M1) && (opponent_score_out >= WIN_M1);
  end

  // Referee FSM with registered outputs, lockout timer and score keeping
  always_ff @(posedge clk_pixel_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state               <= ST_IDLE;
      lock_cnt            <= '0;
      first_is_player     <= 1'b0;
      restart_q           <= 1'b0;
      fight_enable_out    <= 1'b0;
      reset_positions_out <= 1'b0;
      player_score_out    <= 4'd0;
      opponent_score_out  <= 4'd0;
      countdown_out       <= 4'd0;
      touch_event_out     <= 1'b0;
      touch_who_out       <= WHO_NONE;
      winner_out          <= WINNER_NONE;
    end else begin
      reset_positions_out <= 1'b0;
      touch_event_out     <= 1'b0;
      restart_q           <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start_in) begin
            state               <= ST_READY;
            countdown_out       <= READY_N;
            restart_q           <= 1'b1;
            reset_positions_out <= 1'b1;
          end
        end
        ST_READY: begin
          if (sec_tick) begin
            if (countdown_out == 4'd1) begin
              state            <= ST_FENCE;
              countdown_out    <= 4'd0;
              fight_enable_out <= 1'b1;
            end else begin
              countdown_out <= countdown_out - 4'd1;
            end
          end
        end
        ST_FENCE, ST_LOCKOUT: begin
          if (do_double || do_single) begin
            state            <= ST_HALT;
            fight_enable_out <= 1'b0;
            countdown_out    <= HALT_N;
            restart_q        <= 1'b1;
            touch_event_out  <= 1'b1;
            if (do_double) begin
              if (annul_double) begin
                touch_who_out <= WHO_NONE;
              end else begin
                player_score_out   <= sat_inc(player_score_out, WIN);
                opponent_score_out <= sat_inc(opponent_score_out, WIN);
                touch_who_out      <= WHO_DOUBLE;
              end
            end else if (first_is_player) begin
              player_score_out <= sat_inc(player_score_out, WIN);
              touch_who_out    <= WHO_PLAYER;
            end else begin
              opponent_score_out <= sat_inc(opponent_score_out, WIN);
              touch_who_out      <= WHO_OPP;
            end
          end else if (state == ST_FENCE) begin
            if (player_touch_in || opponent_touch_in) begin
              state           <= ST_LOCKOUT;
              first_is_player <= player_touch_in;
              lock_cnt        <= LOCK_LOAD;
            end
          end else begin
            lock_cnt <= lock_cnt - 1'b1;
          end
        end
        ST_HALT: begin
          if (sec_tick) begin
            if (countdown_out == 4'd1) begin
              if ((player_score_out >= WIN) || (opponent_score_out >= WIN)) begin
                state         <= ST_OVER;
                countdown_out <= 4'd0;
                winner_out    <= (player_score_out >= WIN) ? WINNER_PLAYER : WINNER_OPP;
              end else begin
                state               <= ST_READY;
                countdown_out       <= READY_N;
                restart_q           <= 1'b1;
                reset_positions_out <= 1'b1;
              end
            end else begin
              countdown_out <= countdown_out - 4'd1;
            end
          end
        end
        ST_OVER: begin
          if (start_in) begin
            state               <= ST_READY;
            player_score_out    <= 4'd0;
            opponent_score_out  <= 4'd0;
            winner_out          <= WINNER_NONE;
            touch_who_out       <= WHO_NONE;
            countdown_out       <= READY_N;
            restart_q           <= 1'b1;
            reset_positions_out <= 1'b1;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign state_out = state;

endmodule
